pipeline_stage_reg: RTL

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_stage_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipeline_stage_reg.sv
// ============================================================================
//  Module   : pipeline_stage_reg
//  Purpose  : Valid/ready pipeline register with a one-entry skid buffer,
//             multi-source flush with optional bubble, and a flush counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stage_reg #(
    parameter int              WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE      = '0,
    parameter bit              BUBBLE_VALID = 1'b0,
    parameter int              NFLUSH       = 2,
    parameter int              CW           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic              out_bubble,
    input  logic [NFLUSH-1:0] flush,
    output logic [CW-1:0]     flush_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_cnt_max = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             bubble_q, bubble_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;

    logic w_flush_any;
    logic w_accept;
    logic w_fire;

    // Handshake outputs come only from registered state: no out_ready -> in_ready path.
    assign out_valid   = (state_q != ST_EMPTY);
    assign in_ready    = (state_q != ST_SKID);
    assign out_data    = main_q;
    assign out_bubble  = bubble_q;
    assign flush_count = fcnt_q;

    assign w_flush_any = |flush;
    assign w_accept    = in_valid & in_ready;
    assign w_fire      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            main_q   <= BUBBLE;
            skid_q   <= BUBBLE;
            bubble_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            bubble_q <= bubble_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        bubble_d = bubble_q;
        fcnt_d   = fcnt_q;

        if (w_flush_any && (fcnt_q != c_cnt_max)) begin
            fcnt_d = fcnt_q + CW'(1);
        end

        // Flush overrides everything: drop the accept, treat any fire as consumed.
        if (w_flush_any) begin
            main_d   = BUBBLE;
            skid_d   = BUBBLE;
            state_d  = BUBBLE_VALID ? ST_FULL : ST_EMPTY;
            bubble_d = BUBBLE_VALID;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d  = ST_FULL;
                        main_d   = in_data;
                        bubble_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_fire) begin
                        main_d   = in_data;
                        bubble_d = 1'b0;
                    end else if (w_accept) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (w_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_fire) begin
                        state_d  = ST_FULL;
                        main_d   = skid_q;
                        bubble_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
